simple_datapath: RTL and testbench
==================================

# simple_datapath

Register-file and ALU datapath that responds to the SimpleCPU control unit's per-instruction selector, opcode and write strobes. It loads external operands, computes ADD/SUB/SHL/SHR/MOV results and writes them back to a 16-entry register file. It returns the zero/equal/greater flags that the control unit samples to resolve branches. It sits directly beneath the control FSM; the two together form the SimpleCPU core.

## Interface

Parameters:
- `WIDTH`, 8, data width of every register and ALU operand.
- `RESULT_REG`, 1, register index mirrored on `result`.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `load_operands`  in  1  one-cycle strobe: load `op_a_in`/`op_b_in`.
- `op_a_in`  in  WIDTH  operand loaded into R1.
- `op_b_in`  in  WIDTH  operand loaded into R2.
- `opcode`  in  3  ALU operation (0 ADD, 1 SUB, 2 SHL, 3 SHR, 4 MOV; 5–7 no ALU result).
- `reg_a_sel`  in  4  read port A index.
- `reg_b_sel`  in  4  read port B index.
- `dest_reg`  in  4  write index.
- `reg_write`  in  1  write ALU result to `dest_reg` at this edge.
- `zero_flag`  out  1  port A value == 0.
- `equal_flag`  out  1  port A == port B.
- `greater_flag`  out  1  port A > port B, unsigned.
- `result`  out  WIDTH  registered copy of R[`RESULT_REG`].
- `dbg_sel`  in  4  debug read index.
- `dbg_data`  out  WIDTH  combinational read of R[`dbg_sel`].

## Operation

- Register file R0–R15, WIDTH bits each.
  - R0 always reads 0.
  - Writes to R0 are discarded.
- Read ports A/B and `dbg_data` are combinational from current register contents.
- ALU (A = R[`reg_a_sel`], B = R[`reg_b_sel`]):
  - ADD: A+B, truncated to WIDTH.
  - SUB: A−B, modulo 2^WIDTH.
  - SHL: A << B[log2(WIDTH)-1:0], zero fill.
  - SHR: A >> B[log2(WIDTH)-1:0], logical.
  - MOV: A.
  - Opcodes 5–7: result 0. A `reg_write` with these opcodes is ignored and the register file is unchanged.
- Flags are combinational functions of ports A/B only, independent of `opcode`.
- `load_operands`:
  - R1 ← `op_a_in`, R2 ← `op_b_in`, R3–R15 ← 0.
  - Takes priority over `reg_write` in the same cycle; the write is dropped.
- `reg_write`: R[`dest_reg`] ← ALU result at the rising edge. Selectors and opcode present during that cycle are used.
- Write-back alignment with the control unit:
  - Control asserts `reg_write` for the cycle in which its selectors still hold the executing instruction.
  - The write lands at the same edge where control applies the next instruction's selectors.
  - No forwarding is required.
- `result` updates one cycle after R[`RESULT_REG`] changes.

## Timing

- Reset: all registers 0, `result` = 0.
  - Flags after reset: `zero_flag` = 1, `equal_flag` = 1, `greater_flag` = 0.
- Reset mid-operation clears everything immediately (asynchronous); no partial writes survive.
- Flags are valid in the same cycle the selectors are valid (combinational path). Control samples them one cycle after its FETCH edge.
- Write latency: 1 edge. A read of the written register sees the new value from the next cycle.
- `result` latency: 2 edges after the `reg_write` edge, counted from the selectors' cycle.
- `dest_reg` == `reg_a_sel` is legal: the read returns the old value and the write lands at the edge.

## Configuration

- `SIMPLE_DP_STATUS_EN` defined: adds the following outputs.
  - `carry_sticky` (1 bit): set when ADD carries out or SUB borrows on a committed write. Cleared by `load_operands` or reset.
  - `write_count` (8 bits): counts committed writes and saturates at 255. Cleared by `load_operands` or reset.
- Undefined: neither port exists. Core behaviour is identical either way.

## Structure

- Shared package `simple_cpu_pkg`:
  - opcode constants OP_ADD…OP_HALT (shared with the control unit);
  - register-index width;
  - instruction field widths.
- Sub-module `simple_alu`: combinational; takes opcode, A, B; produces result and carry/borrow.
- Register file, load logic and status counters stay in `simple_datapath`.

## Test plan

- Reset, then `dbg_sel` = 0..15 → all `dbg_data` = 0; `zero_flag` = 1, `equal_flag` = 1, `greater_flag` = 0.
- `load_operands` with `op_a_in` = 0x25, `op_b_in` = 0x13; sel A = 1, B = 2 → `greater_flag` = 1, `equal_flag` = 0; R3 = 0.
- ADD A = 1, B = 2, dest 3, `reg_write` → next cycle R3 = 0x38. SUB dest 4 → R4 = 0x12. SUB A = 2, B = 1 → 0xEE (`carry_sticky` = 1 if `SIMPLE_DP_STATUS_EN`).
- R1 = 0x81, R5 = 3: SHL → 0x08; SHR → 0x10. MOV to dest 0 → R0 still reads 0.
- `load_operands` and `reg_write` in the same cycle → R1/R2 take the new operands, R3–R15 = 0, and the write is dropped.
- Write R1 = 0x55 with `RESULT_REG` = 1 → `result` = 0x55 one cycle later. Assert `rst_n` low mid-stream → `result` = 0 asynchronously.

Source files
------------

// File: rtl/simple_cpu_pkg.sv
// Shared SimpleCPU definitions: opcode encoding, register-index width and
// instruction field widths, used by both the control unit and the datapath.
package simple_cpu_pkg;

  localparam int REG_IDX_W  = 4;
  localparam int NUM_REGS   = 1 << REG_IDX_W;
  localparam int OPCODE_W   = 3;
  localparam int INSTR_W    = OPCODE_W + 3 * REG_IDX_W;

  typedef enum logic [OPCODE_W-1:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_SHL  = 3'd2,
    OP_SHR  = 3'd3,
    OP_MOV  = 3'd4,
    OP_BEQ  = 3'd5,
    OP_BGT  = 3'd6,
    OP_HALT = 3'd7
  } opcode_e;

  // True for opcodes that produce a value the register file may accept.
  function automatic logic op_writes(input logic [OPCODE_W-1:0] op);
    return (op <= OP_MOV);
  endfunction

endpackage

// File: rtl/simple_alu.sv
// Combinational ALU for the SimpleCPU datapath. Produces the result, the
// ADD carry-out / SUB borrow, and a valid bit for opcodes that write back.
module simple_alu
  import simple_cpu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  output logic [WIDTH-1:0]    y,
  output logic                carry,
  output logic                valid
);

  localparam int SH_W = $clog2(WIDTH);

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [SH_W-1:0]  sh_amt;

  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};
  assign sh_amt   = b[SH_W-1:0];

  // Operation select; non-ALU opcodes yield zero and are flagged invalid.
  always_comb begin
    y     = '0;
    carry = 1'b0;
    valid = op_writes(opcode);
    case (opcode)
      OP_ADD: begin
        y     = sum_ext[WIDTH-1:0];
        carry = sum_ext[WIDTH];
      end
      OP_SUB: begin
        y     = diff_ext[WIDTH-1:0];
        carry = diff_ext[WIDTH];
      end
      OP_SHL:  y = a << sh_amt;
      OP_SHR:  y = a >> sh_amt;
      OP_MOV:  y = a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/simple_datapath.sv
// SimpleCPU register file + ALU datapath. Sixteen registers (R0 hardwired
// to zero), two combinational read ports feeding the ALU and branch flags,
// a debug read port, and a registered mirror of R[RESULT_REG].
// Optional status outputs (carry_sticky, write_count) are enabled by
// defining SIMPLE_DP_STATUS_EN.
module simple_datapath
  import simple_cpu_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int RESULT_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_operands,
  input  logic [WIDTH-1:0]     op_a_in,
  input  logic [WIDTH-1:0]     op_b_in,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic [REG_IDX_W-1:0] reg_a_sel,
  input  logic [REG_IDX_W-1:0] reg_b_sel,
  input  logic [REG_IDX_W-1:0] dest_reg,
  input  logic                 reg_write,
  output logic                 zero_flag,
  output logic                 equal_flag,
  output logic                 greater_flag,
  output logic [WIDTH-1:0]     result,
`ifdef SIMPLE_DP_STATUS_EN
  output logic                 carry_sticky,
  output logic [7:0]           write_count,
`endif
  input  logic [REG_IDX_W-1:0] dbg_sel,
  output logic [WIDTH-1:0]     dbg_data
);

  // Saturating increment for the committed-write counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [WIDTH-1:0] regs [NUM_REGS];
  logic [WIDTH-1:0] rd_a_p0;
  logic [WIDTH-1:0] rd_b_p0;
  logic [WIDTH-1:0] alu_y_p0;
  logic             alu_vld_p0;
  logic             commit_p0;
  logic [WIDTH-1:0] result_p1;
`ifdef SIMPLE_DP_STATUS_EN
  logic             alu_carry_p0;
`else
  logic             alu_carry_unused;
`endif

  // R0 is never written after reset, so it always reads zero.
  assign rd_a_p0  = regs[reg_a_sel];
  assign rd_b_p0  = regs[reg_b_sel];
  assign dbg_data = regs[dbg_sel];

  assign zero_flag    = (rd_a_p0 == '0);
  assign equal_flag   = (rd_a_p0 == rd_b_p0);
  assign greater_flag = (rd_a_p0 >  rd_b_p0);

  simple_alu #(.WIDTH(WIDTH)) u_alu (
    .opcode (opcode),
    .a      (rd_a_p0),
    .b      (rd_b_p0),
    .y      (alu_y_p0),
`ifdef SIMPLE_DP_STATUS_EN
    .carry  (alu_carry_p0),
`else
    .carry  (alu_carry_unused),
`endif
    .valid  (alu_vld_p0)
  );

  // A write commits only when no operand load competes, the opcode
  // produces a value, and the destination is not the zero register.
  assign commit_p0 = reg_write && !load_operands && alu_vld_p0 &&
                     (dest_reg != '0);

  // ---- stage p0 -> register file ----
  // Register file update: operand load wins over ALU write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (load_operands) begin
      regs[1] <= op_a_in;
      regs[2] <= op_b_in;
      for (int i = 3; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit_p0) begin
      regs[dest_reg] <= alu_y_p0;
    end
  end

  // ---- register file -> stage p1 ----
  // Registered mirror of the designated result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) result_p1 <= '0;
    else        result_p1 <= regs[RESULT_REG];
  end

  assign result = result_p1;

`ifdef SIMPLE_DP_STATUS_EN
  // Status tracking: sticky carry/borrow and saturating write count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_sticky <= 1'b0;
      write_count  <= '0;
    end else if (load_operands) begin
      carry_sticky <= 1'b0;
      write_count  <= '0;
    end else if (commit_p0) begin
      carry_sticky <= carry_sticky | alu_carry_p0;
      write_count  <= sat_inc8(write_count);
    end
  end
`endif

endmodule

// File: tb/tb_simple_datapath.sv
// Directed self-checking bench for simple_datapath (WIDTH=8, RESULT_REG=1).
module tb_simple_datapath;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_operands;
  logic [7:0] op_a_in, op_b_in;
  logic [2:0] opcode;
  logic [3:0] reg_a_sel, reg_b_sel, dest_reg, dbg_sel;
  logic       reg_write;
  logic       zero_flag, equal_flag, greater_flag;
  logic [7:0] result, dbg_data;
`ifdef SIMPLE_DP_STATUS_EN
  logic       carry_sticky;
  logic [7:0] write_count;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  simple_datapath #(.WIDTH(8), .RESULT_REG(1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_operands (load_operands),
    .op_a_in       (op_a_in),
    .op_b_in       (op_b_in),
    .opcode        (opcode),
    .reg_a_sel     (reg_a_sel),
    .reg_b_sel     (reg_b_sel),
    .dest_reg      (dest_reg),
    .reg_write     (reg_write),
    .zero_flag     (zero_flag),
    .equal_flag    (equal_flag),
    .greater_flag  (greater_flag),
    .result        (result),
`ifdef SIMPLE_DP_STATUS_EN
    .carry_sticky  (carry_sticky),
    .write_count   (write_count),
`endif
    .dbg_sel       (dbg_sel),
    .dbg_data      (dbg_data)
  );

  task automatic read_reg(input logic [3:0] idx, output logic [7:0] val);
    dbg_sel = idx;
    #1;
    val = dbg_data;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    load_operands = 1'b0;
    reg_write     = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] a, input logic [7:0] b);
    op_a_in = a; op_b_in = b; load_operands = 1'b1;
    cycle();
  endtask

  task automatic do_op(input logic [2:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic [3:0] d);
    opcode = op; reg_a_sel = a; reg_b_sel = b; dest_reg = d; reg_write = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    logic [7:0] v;
    #3;
    for (int i = 0; i < 16; i++) begin
      read_reg(i[3:0], v);
      total_cnt++;
      if (v !== 8'h00) $display("FAIL reset_reg%0d got %h exp 00", i, v);
      else pass_cnt++;
    end
    total_cnt++;
    if ({zero_flag, equal_flag, greater_flag} !== 3'b110)
      $display("FAIL reset_flags got %b exp 110", {zero_flag, equal_flag, greater_flag});
    else pass_cnt++;
    total_cnt++;
    if (result !== 8'h00) $display("FAIL reset_result got %h exp 00", result);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_load();
    logic [7:0] v;
    do_load(8'h25, 8'h13);
    reg_a_sel = 4'd1; reg_b_sel = 4'd2;
    #1;
    total_cnt++;
    if ({zero_flag, equal_flag, greater_flag} !== 3'b001)
      $display("FAIL load_flags got %b exp 001", {zero_flag, equal_flag, greater_flag});
    else pass_cnt++;
    read_reg(4'd1, v);
    total_cnt++;
    if (v !== 8'h25) $display("FAIL load_r1 got %h exp 25", v); else pass_cnt++;
    read_reg(4'd3, v);
    total_cnt++;
    if (v !== 8'h00) $display("FAIL load_r3 got %h exp 00", v); else pass_cnt++;
  endtask

  task automatic test_alu();
    logic [7:0] v;
    do_op(3'd0, 4'd1, 4'd2, 4'd3);
    read_reg(4'd3, v);
    total_cnt++;
    if (v !== 8'h38) $display("FAIL add_r3 got %h exp 38", v); else pass_cnt++;
`ifdef SIMPLE_DP_STATUS_EN
    total_cnt++;
    if (carry_sticky !== 1'b0) $display("FAIL add_carry got %b exp 0", carry_sticky);
    else pass_cnt++;
`endif
    do_op(3'd1, 4'd1, 4'd2, 4'd4);
    read_reg(4'd4, v);
    total_cnt++;
    if (v !== 8'h12) $display("FAIL sub_r4 got %h exp 12", v); else pass_cnt++;
    do_op(3'd1, 4'd2, 4'd1, 4'd6);
    read_reg(4'd6, v);
    total_cnt++;
    if (v !== 8'hEE) $display("FAIL sub_borrow_r6 got %h exp EE", v); else pass_cnt++;
`ifdef SIMPLE_DP_STATUS_EN
    total_cnt++;
    if (carry_sticky !== 1'b1) $display("FAIL sub_carry got %b exp 1", carry_sticky);
    else pass_cnt++;
    total_cnt++;
    if (write_count !== 8'd3) $display("FAIL write_count got %0d exp 3", write_count);
    else pass_cnt++;
`endif
    reg_a_sel = 4'd3; reg_b_sel = 4'd3;
    #1;
    total_cnt++;
    if ({zero_flag, equal_flag, greater_flag} !== 3'b010)
      $display("FAIL equal_flags got %b exp 010", {zero_flag, equal_flag, greater_flag});
    else pass_cnt++;
  endtask

  task automatic test_shift();
    logic [7:0] v;
    do_load(8'h81, 8'h03);
    do_op(3'd4, 4'd2, 4'd0, 4'd5);
    do_op(3'd2, 4'd1, 4'd5, 4'd6);
    read_reg(4'd6, v);
    total_cnt++;
    if (v !== 8'h08) $display("FAIL shl_r6 got %h exp 08", v); else pass_cnt++;
    do_op(3'd3, 4'd1, 4'd5, 4'd7);
    read_reg(4'd7, v);
    total_cnt++;
    if (v !== 8'h10) $display("FAIL shr_r7 got %h exp 10", v); else pass_cnt++;
    do_op(3'd4, 4'd1, 4'd0, 4'd0);
    read_reg(4'd0, v);
    total_cnt++;
    if (v !== 8'h00) $display("FAIL mov_r0 got %h exp 00", v); else pass_cnt++;
    do_op(3'd5, 4'd1, 4'd5, 4'd6);
    read_reg(4'd6, v);
    total_cnt++;
    if (v !== 8'h08) $display("FAIL op5_ignored got %h exp 08", v); else pass_cnt++;
    // Destination equals read port A: old value during the cycle, new after.
    opcode = 3'd0; reg_a_sel = 4'd6; reg_b_sel = 4'd6; dest_reg = 4'd6; reg_write = 1'b1;
    read_reg(4'd6, v);
    total_cnt++;
    if (v !== 8'h08) $display("FAIL raw_old got %h exp 08", v); else pass_cnt++;
    cycle();
    read_reg(4'd6, v);
    total_cnt++;
    if (v !== 8'h10) $display("FAIL raw_new got %h exp 10", v); else pass_cnt++;
  endtask

  task automatic test_load_priority();
    logic [7:0] v;
    int bad;
    opcode = 3'd0; reg_a_sel = 4'd1; reg_b_sel = 4'd2; dest_reg = 4'd9; reg_write = 1'b1;
    do_load(8'h11, 8'h22);
    read_reg(4'd1, v);
    total_cnt++;
    if (v !== 8'h11) $display("FAIL prio_r1 got %h exp 11", v); else pass_cnt++;
    read_reg(4'd2, v);
    total_cnt++;
    if (v !== 8'h22) $display("FAIL prio_r2 got %h exp 22", v); else pass_cnt++;
    bad = 0;
    for (int i = 3; i < 16; i++) begin
      read_reg(i[3:0], v);
      if (v !== 8'h00) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL prio_clear got %0d nonzero regs exp 0", bad);
    else pass_cnt++;
`ifdef SIMPLE_DP_STATUS_EN
    total_cnt++;
    if ({carry_sticky, write_count} !== 9'd0)
      $display("FAIL prio_status got %b/%0d exp 0/0", carry_sticky, write_count);
    else pass_cnt++;
`endif
  endtask

  task automatic test_result();
    logic [7:0] v;
    do_load(8'h00, 8'h55);
    do_op(3'd4, 4'd2, 4'd0, 4'd1);
    total_cnt++;
    if (result !== 8'h00) $display("FAIL result_early got %h exp 00", result);
    else pass_cnt++;
    cycle();
    total_cnt++;
    if (result !== 8'h55) $display("FAIL result_late got %h exp 55", result);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (result !== 8'h00) $display("FAIL result_async_rst got %h exp 00", result);
    else pass_cnt++;
    read_reg(4'd2, v);
    total_cnt++;
    if (v !== 8'h00) $display("FAIL rst_r2 got %h exp 00", v); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
  endtask

  initial begin
    rst_n = 1'b0; load_operands = 1'b0; reg_write = 1'b0;
    op_a_in = '0; op_b_in = '0; opcode = '0;
    reg_a_sel = '0; reg_b_sel = '0; dest_reg = '0; dbg_sel = '0;
    test_reset();
    test_load();
    test_alu();
    test_shift();
    test_load_priority();
    test_result();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
